axis_flit_deserializer: RTL and testbench



---
 rtl/axis_flit_deserializer.sv | 193 +++++++++++++++++++
 tb/tb_axis_flit_deserializer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_flit_deserializer.sv
// Flit FIFO (sync_fifo) plus beat assembler: SERIALIZATION_FACTOR flits -> one AXI-Stream beat.
// Latency: flit to tvalid is 1 + SF cycles when unstalled; credit_out pulses one cycle after each pop.
// Backpressure: a held output beat stalls only the completing pop; upstream is throttled by credits.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign do_pop    = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push   = push_i && (!full_o || do_pop);
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// NoC egress endpoint: credit-flow flits in, reassembled registered AXI-Stream beats out.
// Latency: SF=1 gives tvalid two cycles after send_in; one flit popped per cycle at most.
// Backpressure: tready low holds the beat; only the completing pop waits, credits return per pop.
module axis_flit_deserializer #(
  parameter int TDATA_WIDTH          = 64,
  parameter int DEST_WIDTH           = 6,
  parameter int SERIALIZATION_FACTOR = 2,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                   clk_noc,
  input  logic                   rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_tvalid,
  input  logic                   axis_tready,
  output logic [TDATA_WIDTH-1:0] axis_tdata,
  output logic                   axis_tlast,
  output logic [DEST_WIDTH-1:0]  axis_tdest,
  output logic                   overflow
);
  localparam int SF    = SERIALIZATION_FACTOR;
  localparam int CNT_W = (SF > 1) ? $clog2(SF) : 1;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
  } flit_t;

  flit_t                  push_flit, head;
  logic                   fifo_full, fifo_empty;
  logic                   pop, complete, out_free;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TDATA_WIDTH-1:0] asm_q, asm_d, beat;
  logic                   tvalid_q, tvalid_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic [DEST_WIDTH-1:0]  tdest_q, tdest_d;
  logic                   credit_q;
  logic                   overflow_q, overflow_d;

  assign push_flit = '{data: data_in, dest: dest_in, is_tail: is_tail_in};

  sync_fifo #(
    .WIDTH($bits(flit_t)),
    .DEPTH(FLIT_BUFFER_DEPTH)
  ) u_flit_fifo (
    .clk_i     (clk_noc),
    .rst_i     (rst_noc_sync),
    .push_i    (send_in),
    .push_dat_i(push_flit),
    .pop_i     (pop),
    .pop_dat_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign complete = (cnt_q == CNT_W'(SF - 1)) || head.is_tail;
  assign out_free = !tvalid_q || axis_tready;
  assign pop      = !fifo_empty && (!complete || out_free);

  // Slices at and above cnt are still zero in asm_q, so an early tail yields a zero-padded beat.
  always_comb begin
    beat = asm_q;
    for (int s = 0; s < SF; s++) begin
      if (cnt_q == CNT_W'(s)) beat[s*FLIT_WIDTH +: FLIT_WIDTH] = head.data;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    tdest_d    = tdest_q;
    overflow_d = overflow_q || (send_in && fifo_full && !pop);
    if (tvalid_q && axis_tready) tvalid_d = 1'b0;
    if (pop) begin
      if (complete) begin
        tvalid_d = 1'b1;
        tdata_d  = beat;
        tlast_d  = head.is_tail;
        tdest_d  = head.dest;
        cnt_d    = '0;
        asm_d    = '0;
      end else begin
        asm_d = beat;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      cnt_q      <= '0;
      asm_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tdest_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tdest_q    <= tdest_d;
      credit_q   <= pop;
      overflow_q <= overflow_d;
    end
  end

  assign credit_out  = credit_q;
  assign axis_tvalid = tvalid_q;
  assign axis_tdata  = tdata_q;
  assign axis_tlast  = tlast_q;
  assign axis_tdest  = tdest_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_axis_flit_deserializer.sv
// Directed bench: SF=2 instance for assembly/backpressure/overflow/reset, SF=1 instance for throughput.
module tb_axis_flit_deserializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] data_in;
  logic [5:0]  dest_in;
  logic        is_tail_in, send_in, credit_out;
  logic        axis_tvalid, axis_tready, axis_tlast, overflow;
  logic [63:0] axis_tdata;
  logic [5:0]  axis_tdest;

  logic [31:0] data_1;
  logic [5:0]  dest_1;
  logic        tail_1, send_1, credit_1, tvalid_1, tready_1, tlast_1, ovf_1;
  logic [31:0] tdata_1;
  logic [5:0]  tdest_1;

  int n_checks = 0;
  int n_pass   = 0;

  axis_flit_deserializer dut (
    .clk_noc(clk), .rst_noc_sync(rst),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
    .axis_tlast(axis_tlast), .axis_tdest(axis_tdest), .overflow(overflow)
  );

  axis_flit_deserializer #(.TDATA_WIDTH(32), .SERIALIZATION_FACTOR(1)) dut1 (
    .clk_noc(clk), .rst_noc_sync(rst),
    .data_in(data_1), .dest_in(dest_1), .is_tail_in(tail_1), .send_in(send_1),
    .credit_out(credit_1),
    .axis_tvalid(tvalid_1), .axis_tready(tready_1), .axis_tdata(tdata_1),
    .axis_tlast(tlast_1), .axis_tdest(tdest_1), .overflow(ovf_1)
  );

  logic [63:0] bq_data [$];
  logic        bq_last [$];
  logic [5:0]  bq_dest [$];
  int          credit_total = 0;

  always @(posedge clk) begin
    if (!rst && axis_tvalid && axis_tready) begin
      bq_data.push_back(axis_tdata);
      bq_last.push_back(axis_tlast);
      bq_dest.push_back(axis_tdest);
    end
    if (!rst && credit_out) credit_total <= credit_total + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic [31:0] d, input logic [5:0] de, input logic t);
    send_in = s; data_in = d; dest_in = de; is_tail_in = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++; if (axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", axis_tvalid); else n_pass++;
    n_checks++; if (axis_tdata !== 64'h0) $display("FAIL reset_tdata: got %h expected 0", axis_tdata); else n_pass++;
    n_checks++; if (axis_tlast !== 1'b0) $display("FAIL reset_tlast: got %b expected 0", axis_tlast); else n_pass++;
    n_checks++; if (axis_tdest !== 6'h0) $display("FAIL reset_tdest: got %h expected 0", axis_tdest); else n_pass++;
    n_checks++; if (credit_out !== 1'b0) $display("FAIL reset_credit: got %b expected 0", credit_out); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int c0, b0;
    c0 = credit_total; b0 = bq_data.size();
    axis_tready = 1'b1;
    drive(1'b1, 32'h11111111, 6'h05, 1'b0); step();
    n_checks++; if (credit_out !== 1'b0) $display("FAIL basic_credit_c1: got %b expected 0", credit_out); else n_pass++;
    drive(1'b1, 32'h22222222, 6'h05, 1'b1); step();
    n_checks++; if (credit_out !== 1'b1) $display("FAIL basic_credit_c2: got %b expected 1", credit_out); else n_pass++;
    n_checks++; if (axis_tvalid !== 1'b0) $display("FAIL basic_tvalid_c2: got %b expected 0", axis_tvalid); else n_pass++;
    drive(1'b0, 32'h0, 6'h0, 1'b0); step();
    n_checks++; if (axis_tvalid !== 1'b1) $display("FAIL basic_tvalid_c3: got %b expected 1", axis_tvalid); else n_pass++;
    n_checks++; if (axis_tdata !== 64'h2222222211111111) $display("FAIL basic_tdata: got %h expected 2222222211111111", axis_tdata); else n_pass++;
    n_checks++; if (axis_tlast !== 1'b1) $display("FAIL basic_tlast: got %b expected 1", axis_tlast); else n_pass++;
    n_checks++; if (axis_tdest !== 6'h05) $display("FAIL basic_tdest: got %h expected 05", axis_tdest); else n_pass++;
    n_checks++; if (credit_out !== 1'b1) $display("FAIL basic_credit_c3: got %b expected 1", credit_out); else n_pass++;
    step();
    n_checks++; if (axis_tvalid !== 1'b0) $display("FAIL basic_tvalid_c4: got %b expected 0", axis_tvalid); else n_pass++;
    n_checks++; if (credit_out !== 1'b0) $display("FAIL basic_credit_c4: got %b expected 0", credit_out); else n_pass++;
    n_checks++; if (credit_total - c0 !== 2) $display("FAIL basic_credit_count: got %0d expected 2", credit_total - c0); else n_pass++;
    n_checks++; if (bq_data.size() - b0 !== 1) $display("FAIL basic_beat_count: got %0d expected 1", bq_data.size() - b0); else n_pass++;
  endtask

  task automatic test_backpressure();
    int credits, sent, c0, b0;
    logic stable;
    logic [31:0] flits [8];
    for (int i = 0; i < 8; i++) flits[i] = 32'hB000_0000 + 32'(i);
    credits = 4; sent = 0; stable = 1'b1;
    c0 = credit_total; b0 = bq_data.size();
    axis_tready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (credit_out) credits++;
      if (credits > 0 && sent < 8) begin
        drive(1'b1, flits[sent], 6'(10 + sent / 2), (sent % 2) == 1);
        sent++; credits--;
      end else drive(1'b0, 32'h0, 6'h0, 1'b0);
      step();
      if (cyc >= 2 && (axis_tvalid !== 1'b1 || axis_tdata !== {flits[1], flits[0]})) stable = 1'b0;
    end
    n_checks++; if (stable !== 1'b1) $display("FAIL bp_beat0_stable: got %b expected 1", stable); else n_pass++;
    n_checks++; if (sent !== 7) $display("FAIL bp_accepted: got %0d expected 7", sent); else n_pass++;
    n_checks++; if (credit_total - c0 !== 3) $display("FAIL bp_credits_stalled: got %0d expected 3", credit_total - c0); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL bp_overflow_stalled: got %b expected 0", overflow); else n_pass++;
    axis_tready = 1'b1;
    for (int cyc = 0; cyc < 60 && (bq_data.size() - b0) < 4; cyc++) begin
      if (credit_out) credits++;
      if (credits > 0 && sent < 8) begin
        drive(1'b1, flits[sent], 6'(10 + sent / 2), (sent % 2) == 1);
        sent++; credits--;
      end else drive(1'b0, 32'h0, 6'h0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 6'h0, 1'b0);
    repeat (3) step();
    n_checks++;
    if (bq_data.size() - b0 !== 4) $display("FAIL bp_beat_count: got %0d expected 4", bq_data.size() - b0);
    else begin
      n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (bq_data[b0+k] !== {flits[2*k+1], flits[2*k]}) $display("FAIL bp_tdata_%0d: got %h expected %h", k, bq_data[b0+k], {flits[2*k+1], flits[2*k]}); else n_pass++;
        n_checks++; if (bq_last[b0+k] !== 1'b1) $display("FAIL bp_tlast_%0d: got %b expected 1", k, bq_last[b0+k]); else n_pass++;
        n_checks++; if (bq_dest[b0+k] !== 6'(10 + k)) $display("FAIL bp_tdest_%0d: got %0d expected %0d", k, bq_dest[b0+k], 10 + k); else n_pass++;
      end
    end
    n_checks++; if (credit_total - c0 !== 8) $display("FAIL bp_credits_total: got %0d expected 8", credit_total - c0); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL bp_overflow_end: got %b expected 0", overflow); else n_pass++;
  endtask

  task automatic test_early_tail();
    int b0;
    b0 = bq_data.size();
    axis_tready = 1'b1;
    drive(1'b1, 32'hAAAAAAAA, 6'h03, 1'b1); step();
    drive(1'b1, 32'h33333333, 6'h07, 1'b0); step();
    drive(1'b1, 32'h44444444, 6'h07, 1'b1); step();
    drive(1'b0, 32'h0, 6'h0, 1'b0);
    for (int k = 0; k < 30 && (bq_data.size() - b0) < 2; k++) step();
    n_checks++;
    if (bq_data.size() - b0 !== 2) $display("FAIL early_beat_count: got %0d expected 2", bq_data.size() - b0);
    else begin
      n_pass++;
      n_checks++; if (bq_data[b0] !== 64'h00000000AAAAAAAA) $display("FAIL early_tdata: got %h expected 00000000aaaaaaaa", bq_data[b0]); else n_pass++;
      n_checks++; if (bq_last[b0] !== 1'b1) $display("FAIL early_tlast: got %b expected 1", bq_last[b0]); else n_pass++;
      n_checks++; if (bq_dest[b0] !== 6'h03) $display("FAIL early_tdest: got %h expected 03", bq_dest[b0]); else n_pass++;
      n_checks++; if (bq_data[b0+1] !== 64'h4444444433333333) $display("FAIL early_next_tdata: got %h expected 4444444433333333", bq_data[b0+1]); else n_pass++;
      n_checks++; if (bq_dest[b0+1] !== 6'h07) $display("FAIL early_next_tdest: got %h expected 07", bq_dest[b0+1]); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    int b0;
    logic [31:0] g [12];
    logic [63:0] exp_d [5];
    for (int i = 0; i < 12; i++) g[i] = 32'hD000_0000 + 32'(i);
    exp_d[0] = {g[2], g[1]}; exp_d[1] = {g[4], g[3]}; exp_d[2] = {g[6], g[5]};
    exp_d[3] = {g[8], g[7]}; exp_d[4] = {g[11], g[9]};
    b0 = bq_data.size();
    axis_tready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, g[i], 6'h21, 1'b0); step();
    end
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_fill: got %b expected 0", overflow); else n_pass++;
    axis_tready = 1'b1;
    drive(1'b1, g[8], 6'h21, 1'b0); step();
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_full_pop_push: got %b expected 0", overflow); else n_pass++;
    axis_tready = 1'b0;
    drive(1'b1, g[9], 6'h21, 1'b0); step();
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_refill: got %b expected 0", overflow); else n_pass++;
    drive(1'b1, g[10], 6'h21, 1'b0); step();
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow); else n_pass++;
    drive(1'b0, 32'h0, 6'h0, 1'b0);
    repeat (3) step();
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else n_pass++;
    axis_tready = 1'b1;
    repeat (10) step();
    drive(1'b1, g[11], 6'h21, 1'b1); step();
    drive(1'b0, 32'h0, 6'h0, 1'b0);
    for (int k = 0; k < 30 && (bq_data.size() - b0) < 5; k++) step();
    repeat (3) step();
    n_checks++;
    if (bq_data.size() - b0 !== 5) $display("FAIL ovf_beat_count: got %0d expected 5", bq_data.size() - b0);
    else begin
      n_pass++;
      for (int k = 0; k < 5; k++) begin
        n_checks++; if (bq_data[b0+k] !== exp_d[k]) $display("FAIL ovf_tdata_%0d: got %h expected %h", k, bq_data[b0+k], exp_d[k]); else n_pass++;
        n_checks++; if (bq_last[b0+k] !== (k == 4)) $display("FAIL ovf_tlast_%0d: got %b expected %b", k, bq_last[b0+k], k == 4); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int b0;
    axis_tready = 1'b0;
    drive(1'b1, 32'hE1E1E1E1, 6'h09, 1'b0); step();
    drive(1'b1, 32'hE2E2E2E2, 6'h09, 1'b1); step();
    drive(1'b1, 32'hE3E3E3E3, 6'h09, 1'b0); step();
    drive(1'b1, 32'hE4E4E4E4, 6'h09, 1'b1); step();
    drive(1'b0, 32'h0, 6'h0, 1'b0);
    n_checks++; if (axis_tvalid !== 1'b1) $display("FAIL rst_pre_tvalid: got %b expected 1", axis_tvalid); else n_pass++;
    rst = 1'b1; axis_tready = 1'b1;
    step();
    n_checks++; if (axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b expected 0", axis_tvalid); else n_pass++;
    n_checks++; if (axis_tdata !== 64'h0) $display("FAIL rst_tdata: got %h expected 0", axis_tdata); else n_pass++;
    n_checks++; if (axis_tlast !== 1'b0) $display("FAIL rst_tlast: got %b expected 0", axis_tlast); else n_pass++;
    n_checks++; if (axis_tdest !== 6'h0) $display("FAIL rst_tdest: got %h expected 0", axis_tdest); else n_pass++;
    n_checks++; if (credit_out !== 1'b0) $display("FAIL rst_credit: got %b expected 0", credit_out); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b expected 0", overflow); else n_pass++;
    rst = 1'b0;
    b0 = bq_data.size();
    drive(1'b1, 32'h66666666, 6'h0A, 1'b0); step();
    drive(1'b1, 32'h77777777, 6'h0A, 1'b1); step();
    drive(1'b0, 32'h0, 6'h0, 1'b0);
    for (int k = 0; k < 30 && (bq_data.size() - b0) < 1; k++) step();
    repeat (5) step();
    n_checks++;
    if (bq_data.size() - b0 !== 1) $display("FAIL rst_beat_count: got %0d expected 1", bq_data.size() - b0);
    else begin
      n_pass++;
      n_checks++; if (bq_data[b0] !== 64'h7777777766666666) $display("FAIL rst_next_tdata: got %h expected 7777777766666666", bq_data[b0]); else n_pass++;
      n_checks++; if (bq_dest[b0] !== 6'h0A) $display("FAIL rst_next_tdest: got %h expected 0a", bq_dest[b0]); else n_pass++;
      n_checks++; if (bq_last[b0] !== 1'b1) $display("FAIL rst_next_tlast: got %b expected 1", bq_last[b0]); else n_pass++;
    end
  endtask

  task automatic test_throughput();
    int credits, sent, got, bad, window;
    logic v1, v2, c2, l2;
    logic [5:0] d2;
    credits = 4; sent = 0; got = 0; bad = 0; window = 0;
    v1 = 1'bx; v2 = 1'bx; c2 = 1'bx; l2 = 1'bx; d2 = 'x;
    tready_1 = 1'b1;
    for (int s = 0; s < 40; s++) begin
      if (credit_1) credits++;
      if (tvalid_1) begin
        if (tdata_1 !== (32'hC000_0000 + 32'(got))) bad++;
        got++;
        if (s >= 10 && s < 30) window++;
      end
      if (s == 1) v1 = tvalid_1;
      if (s == 2) begin v2 = tvalid_1; c2 = credit_1; l2 = tlast_1; d2 = tdest_1; end
      if (credits > 0 && s < 30) begin
        send_1 = 1'b1; data_1 = 32'hC000_0000 + 32'(sent); dest_1 = 6'h2A; tail_1 = 1'b1;
        sent++; credits--;
      end else send_1 = 1'b0;
      step();
    end
    n_checks++; if (v1 !== 1'b0) $display("FAIL thr_tvalid_t1: got %b expected 0", v1); else n_pass++;
    n_checks++; if (v2 !== 1'b1) $display("FAIL thr_tvalid_t2: got %b expected 1", v2); else n_pass++;
    n_checks++; if (c2 !== 1'b1) $display("FAIL thr_credit_t2: got %b expected 1", c2); else n_pass++;
    n_checks++; if (l2 !== 1'b1) $display("FAIL thr_tlast: got %b expected 1", l2); else n_pass++;
    n_checks++; if (d2 !== 6'h2A) $display("FAIL thr_tdest: got %h expected 2a", d2); else n_pass++;
    n_checks++; if (window !== 20) $display("FAIL thr_steady_beats: got %0d expected 20", window); else n_pass++;
    n_checks++; if (sent !== 30) $display("FAIL thr_sent: got %0d expected 30", sent); else n_pass++;
    n_checks++; if (got !== 30) $display("FAIL thr_received: got %0d expected 30", got); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL thr_order: got %0d bad beats expected 0", bad); else n_pass++;
    n_checks++; if (ovf_1 !== 1'b0) $display("FAIL thr_overflow: got %b expected 0", ovf_1); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    send_in = 1'b0; data_in = '0; dest_in = '0; is_tail_in = 1'b0; axis_tready = 1'b0;
    send_1 = 1'b0; data_1 = '0; dest_1 = '0; tail_1 = 1'b0; tready_1 = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_early_tail();
    test_overflow();
    test_reset_mid_packet();
    test_throughput();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
